// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with zero-skew sync/video/coordinate outputs.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int unsigned HTOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_DISPLAY + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);

  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          video_on_next;
  logic          vblank_next;
  logic          line_start_next;
  logic          frame_start_next;

  // Next pixel position and its decode; registering these keeps all outputs aligned.
  always_comb begin
    x_next = pixel_x + CW'(1);
    y_next = pixel_y;
    if (pixel_x == H_LAST) begin
      x_next = '0;
      y_next = (pixel_y == V_LAST) ? '0 : pixel_y + CW'(1);
    end
    hsync_next       = ((x_next >= CW'(HS_START)) && (x_next < CW'(HS_END))) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_next       = ((y_next >= CW'(VS_START)) && (y_next < CW'(VS_END))) ? V_SYNC_POL : ~V_SYNC_POL;
    video_on_next    = (x_next < CW'(H_DISPLAY)) && (y_next < CW'(V_DISPLAY));
    vblank_next      = (y_next >= CW'(V_DISPLAY));
    line_start_next  = (x_next == '0);
    frame_start_next = (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      video_on    <= 1'b0;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      pixel_x     <= x_next;
      pixel_y     <= y_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      video_on    <= video_on_next;
      vblank      <= vblank_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end else begin
      // Strobes are single-cycle even when the pixel clock enable is sparse.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if (ce && frame_start_next) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
